pixel_addr_pipe: RTL

PIXEL_ADDR_PIPE -- requirements
Module: pixel_addr_pipe

---
 rtl/geo_pkg.sv | 57 +++++
 rtl/pixel_addr_mac.sv | 30 +++
 rtl/pixel_addr_pipe.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/geo_pkg.sv
// Shared codes and field layout for the pixel address pipeline.
package geo_pkg;

  // Input AUX codes (cmd_data[35:32]).
  localparam logic [3:0] AuxNop0    = 4'd0;
  localparam logic [3:0] AuxDst1    = 4'd1;
  localparam logic [3:0] AuxDst2    = 4'd2;
  localparam logic [3:0] AuxDst3    = 4'd3;
  localparam logic [3:0] AuxDst4    = 4'd4;
  localparam logic [3:0] AuxNop5    = 4'd5;
  localparam logic [3:0] AuxSrc6    = 4'd6;
  localparam logic [3:0] AuxPass7   = 4'd7;
  localparam logic [3:0] AuxDstH    = 4'd8;
  localparam logic [3:0] AuxSrcH    = 4'd9;
  localparam logic [3:0] AuxPass10  = 4'd10;
  localparam logic [3:0] AuxPass11  = 4'd11;
  localparam logic [3:0] AuxDstWb   = 4'd12;
  localparam logic [3:0] AuxSrcWb   = 4'd13;
  localparam logic [3:0] AuxDstBase = 4'd14;
  localparam logic [3:0] AuxSrcBase = 4'd15;

  // Output cmd codes: every emitting command reports its own AUX code.
  localparam int unsigned OutCmdW    = 4;
  localparam logic [3:0]  OutDst1    = AuxDst1;
  localparam logic [3:0]  OutDst2    = AuxDst2;
  localparam logic [3:0]  OutDst3    = AuxDst3;
  localparam logic [3:0]  OutDst4    = AuxDst4;
  localparam logic [3:0]  OutSrc6    = AuxSrc6;
  localparam logic [3:0]  OutPass7   = AuxPass7;
  localparam logic [3:0]  OutPass10  = AuxPass10;
  localparam logic [3:0]  OutPass11  = AuxPass11;

  // Bits-per-pixel codes; the value is also the log2 shift.
  typedef enum logic [2:0] {
    Bpp1  = 3'd0,
    Bpp2  = 3'd1,
    Bpp4  = 3'd2,
    Bpp8  = 3'd3,
    Bpp16 = 3'd4
  } bpp_code_e;

  // pix_data field offsets, relative to ADDR_W (address occupies [ADDR_W-1:0]).
  localparam int unsigned PixBitLsb    = 0;
  localparam int unsigned PixBppLsb    = 4;
  localparam int unsigned PixColourLsb = 8;
  localparam int unsigned PixCmdLsb    = 16;
  localparam int unsigned PixExtraW    = 20;

  // Undefined codes 5..7 behave as 16 bpp.
  function automatic logic [2:0] bpp_shift(input logic [2:0] code);
    if (code > 3'(Bpp16)) begin
      return 3'(Bpp16);
    end
    return code;
  endfunction

endpackage

// File: rtl/pixel_addr_mac.sv
// Registered multiply-add: sum = y * width + x, loaded only when en is high.
module pixel_addr_mac #(
  parameter int unsigned COORD_W = 12,
  parameter int unsigned DIM_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [COORD_W-1:0]       x,
  input  logic [COORD_W-1:0]       y,
  input  logic [DIM_W-1:0]         width,
  output logic [COORD_W+DIM_W:0]   sum
);

  localparam int unsigned SumW = COORD_W + DIM_W + 1;

  logic [SumW-1:0] sum_q;

  // Full-precision product; one extra bit absorbs the +x carry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else if (en) begin
      sum_q <= SumW'(y) * SumW'(width) + SumW'(x);
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/pixel_addr_pipe.sv
// Three-stage pixel command to memory address pipeline with clipping.
// S1 registers the command, S2 holds y*width+x and the clip decision,
// S3 is the output register (shift by bpp, add base).
module pixel_addr_pipe
  import geo_pkg::*;
#(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned COORD_W = 12,
  parameter int unsigned DIM_W   = 16,
  parameter int unsigned CLIP_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [35:0]            cmd_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [ADDR_W+19:0]     pix_data,
  output logic [CLIP_W-1:0]      clip_count
);

  localparam int unsigned MacW = COORD_W + DIM_W + 1;
  localparam int unsigned OffW = MacW + 4;
  localparam int unsigned CmpW = COORD_W + DIM_W;
  localparam int unsigned PixW = ADDR_W + PixExtraW;

  logic advance;

  // S1 state
  logic        s1_valid_q;
  logic [3:0]  s1_aux_q;
  logic [31:0] s1_data_q;

  // S1 decode
  logic               s1_is_dst, s1_is_src, s1_is_pass, s1_clip;
  logic [COORD_W-1:0] s1_x, s1_y;
  logic [DIM_W-1:0]   sel_w, sel_h;

  // Surface configuration
  logic [DIM_W-1:0]  dst_width_q, dst_height_q, src_width_q, src_height_q;
  logic [ADDR_W-1:0] dst_base_q, src_base_q;
  logic [2:0]        dst_code_q, src_code_q;

  // S2 state
  logic              s2_valid_q, s2_pass_q, s2_src_q, s2_clip_q;
  logic [3:0]        s2_aux_q;
  logic [31:0]       s2_data_q;
  logic [ADDR_W-1:0] s2_base_q;
  logic [2:0]        s2_code_q;
  logic [MacW-1:0]   dst_sum, src_sum;

  // S3 datapath and state
  logic [MacW-1:0]   sel_sum;
  logic [OffW-1:0]   bitoff;
  logic [ADDR_W-1:0] byte_addr;
  logic [PixW-1:0]   pix_data_d, pix_data_q;
  logic              pix_out_valid, pix_valid_q;
  logic [CLIP_W-1:0] clip_count_q;

  assign advance   = !pix_valid_q || pix_ready;
  assign cmd_ready = advance;

  // S1: capture every accepted command, bubbles otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_aux_q   <= '0;
      s1_data_q  <= '0;
    end else if (advance) begin
      s1_valid_q <= cmd_valid;
      if (cmd_valid) begin
        s1_aux_q  <= cmd_data[35:32];
        s1_data_q <= cmd_data[31:0];
      end
    end
  end

  // S1 decode: command class, coordinates and clip test against the selected surface.
  always_comb begin
    s1_is_dst  = 1'b0;
    s1_is_src  = 1'b0;
    s1_is_pass = 1'b0;
    case (s1_aux_q)
      AuxDst1, AuxDst2, AuxDst3, AuxDst4: s1_is_dst  = 1'b1;
      AuxSrc6:                            s1_is_src  = 1'b1;
      AuxPass7, AuxPass10, AuxPass11:     s1_is_pass = 1'b1;
      default: ;
    endcase
    s1_x    = COORD_W'(s1_data_q[11:0]);
    s1_y    = COORD_W'(s1_data_q[23:12]);
    sel_w   = s1_is_src ? src_width_q  : dst_width_q;
    sel_h   = s1_is_src ? src_height_q : dst_height_q;
    // A zero dimension makes every coordinate out of range.
    s1_clip = (CmpW'(s1_x) >= CmpW'(sel_w)) || (CmpW'(s1_y) >= CmpW'(sel_h));
  end

  // Config takes effect as it leaves S1, so older commands already in S2 see the
  // previous values and the next accepted command sees the new ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dst_width_q  <= '0;
      dst_height_q <= '0;
      src_width_q  <= '0;
      src_height_q <= '0;
      dst_base_q   <= '0;
      src_base_q   <= '0;
      dst_code_q   <= '0;
      src_code_q   <= '0;
    end else if (advance && s1_valid_q) begin
      case (s1_aux_q)
        AuxDstWb: begin
          dst_width_q <= DIM_W'(s1_data_q[15:0]);
          dst_code_q  <= s1_data_q[26:24];
        end
        AuxSrcWb: begin
          src_width_q <= DIM_W'(s1_data_q[15:0]);
          src_code_q  <= s1_data_q[26:24];
        end
        AuxDstH:    dst_height_q <= DIM_W'(s1_data_q[15:0]);
        AuxSrcH:    src_height_q <= DIM_W'(s1_data_q[15:0]);
        AuxDstBase: dst_base_q   <= s1_data_q[ADDR_W-1:0];
        AuxSrcBase: src_base_q   <= s1_data_q[ADDR_W-1:0];
        default: ;
      endcase
    end
  end

  pixel_addr_mac #(
    .COORD_W (COORD_W),
    .DIM_W   (DIM_W)
  ) u_mac_dst (
    .clk   (clk),
    .reset (reset),
    .en    (advance && s1_valid_q && s1_is_dst),
    .x     (s1_x),
    .y     (s1_y),
    .width (dst_width_q),
    .sum   (dst_sum)
  );

  pixel_addr_mac #(
    .COORD_W (COORD_W),
    .DIM_W   (DIM_W)
  ) u_mac_src (
    .clk   (clk),
    .reset (reset),
    .en    (advance && s1_valid_q && s1_is_src),
    .x     (s1_x),
    .y     (s1_y),
    .width (src_width_q),
    .sum   (src_sum)
  );

  // S2: only commands that may emit (or be counted as clipped) stay valid here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_q <= 1'b0;
      s2_pass_q  <= 1'b0;
      s2_src_q   <= 1'b0;
      s2_clip_q  <= 1'b0;
      s2_aux_q   <= '0;
      s2_data_q  <= '0;
      s2_base_q  <= '0;
      s2_code_q  <= '0;
    end else if (advance) begin
      s2_valid_q <= s1_valid_q && (s1_is_dst || s1_is_src || s1_is_pass);
      s2_pass_q  <= s1_is_pass;
      s2_src_q   <= s1_is_src;
      s2_clip_q  <= (s1_is_dst || s1_is_src) && s1_clip;
      s2_aux_q   <= s1_aux_q;
      s2_data_q  <= s1_data_q;
      s2_base_q  <= s1_is_src ? src_base_q : dst_base_q;
      s2_code_q  <= s1_is_src ? src_code_q : dst_code_q;
    end
  end

  // S3 datapath: bit offset, 16-bit word aligned byte address, output packing.
  always_comb begin
    sel_sum      = s2_src_q ? src_sum : dst_sum;
    bitoff       = OffW'(sel_sum) << bpp_shift(s2_code_q);
    byte_addr    = s2_base_q + ADDR_W'({bitoff[OffW-1:4], 1'b0});
    byte_addr[0] = 1'b0;

    pix_data_d = '0;
    pix_data_d[ADDR_W+PixCmdLsb +: OutCmdW] = s2_aux_q;
    if (s2_pass_q) begin
      pix_data_d[31:0] = s2_data_q;
    end else begin
      pix_data_d[ADDR_W+PixColourLsb +: 8] = s2_data_q[31:24];
      pix_data_d[ADDR_W+PixBppLsb +: 4]    = {1'b0, s2_code_q};
      pix_data_d[ADDR_W+PixBitLsb +: 4]    = bitoff[3:0];
      pix_data_d[ADDR_W-1:0]               = byte_addr;
    end
    pix_out_valid = s2_valid_q && !s2_clip_q;
  end

  // S3 output register and saturating clip counter; data holds while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      clip_count_q <= '0;
    end else if (advance) begin
      pix_valid_q <= pix_out_valid;
      if (pix_out_valid) begin
        pix_data_q <= pix_data_d;
      end
      if (s2_valid_q && s2_clip_q && (clip_count_q != '1)) begin
        clip_count_q <= clip_count_q + 1'b1;
      end
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign clip_count = clip_count_q;

endmodule
